// File: rtl/vx_warp_ibuffer.sv
// rtl/vx_warp_ibuffer.sv - per-warp instruction FIFOs with round-robin issue into a registered output slot
module vx_warp_ibuffer #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 2,
    parameter int DATAW     = 64,
    localparam int WIS_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIS_W-1:0]     in_wis,
    input  logic [DATAW-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIS_W-1:0]     out_wis,
    output logic [DATAW-1:0]     out_data,
    input  logic                 out_ready,
    output logic [NUM_WARPS-1:0] warp_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATAW-1:0] mem_q   [NUM_WARPS][DEPTH];
    logic [DATAW-1:0] mem_d   [NUM_WARPS][DEPTH];
    logic [PTR_W-1:0] rptr_q  [NUM_WARPS];
    logic [PTR_W-1:0] rptr_d  [NUM_WARPS];
    logic [PTR_W-1:0] wptr_q  [NUM_WARPS];
    logic [PTR_W-1:0] wptr_d  [NUM_WARPS];
    logic [CNT_W-1:0] count_q [NUM_WARPS];
    logic [CNT_W-1:0] count_d [NUM_WARPS];
    logic [WIS_W-1:0] rr_q, rr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIS_W-1:0] out_wis_q, out_wis_d;
    logic [DATAW-1:0] out_data_q, out_data_d;

    logic             wis_ok;
    logic             enq;
    logic             load;
    logic             found;
    logic [WIS_W-1:0] grant;

    assign wis_ok   = int'(in_wis) < NUM_WARPS;
    assign in_ready = wis_ok && (count_q[in_wis] != CNT_W'(DEPTH));
    assign enq      = in_valid && in_ready && !reset;

    // First non-empty warp at or after rr_q, wrapping around.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
            if (!found && count_q[idx] != '0) begin
                found = 1'b1;
                grant = WIS_W'(idx);
            end
        end
    end

    assign load = (!out_valid_q || out_ready) && found;

    always_comb begin
        mem_d       = mem_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_wis_d   = out_wis_q;
        out_data_d  = out_data_q;

        if (enq) begin
            mem_d[in_wis][wptr_q[in_wis]] = in_data;
            wptr_d[in_wis]                = wptr_q[in_wis] + 1'b1;
        end

        if (load) begin
            out_valid_d  = 1'b1;
            out_wis_d    = grant;
            out_data_d   = mem_q[grant][rptr_q[grant]];
            rptr_d[grant] = rptr_q[grant] + 1'b1;
            rr_d         = (grant == WIS_W'(NUM_WARPS - 1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Same-warp enqueue and dequeue cancel out in the count.
        for (int w = 0; w < NUM_WARPS; w++) begin
            count_d[w] = count_q[w]
                       + CNT_W'(enq && (in_wis == WIS_W'(w)))
                       - CNT_W'(load && (grant == WIS_W'(w)));
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q      <= '{default: '0};
            wptr_q      <= '{default: '0};
            count_q     <= '{default: '0};
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_wis_q   <= '0;
            out_data_q  <= '0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_wis_q   <= out_wis_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_wis   = out_wis_q;
    assign out_data  = out_data_q;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_empty
        assign warp_empty[w] = (count_q[w] == '0);
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(in_valid && !wis_ok))
                else $error("in_wis %0d out of range", in_wis);
            for (int w = 0; w < NUM_WARPS; w++) begin
                assert (count_q[w] <= CNT_W'(DEPTH))
                    else $error("warp %0d count %0d out of range", w, count_q[w]);
            end
            if (out_valid_q && !out_ready) begin
                assert (out_data_d == out_data_q && out_wis_d == out_wis_q)
                    else $error("presented instruction changed while stalled");
            end
        end
    end
`endif
endmodule
